// File: rtl/rtc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared constants, FSM encoding and BCD helper for the RTC
//               bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    // Timekeeping register addresses
    localparam logic [3:0] REG_SEC  = 4'h0;
    localparam logic [3:0] REG_MIN  = 4'h1;
    localparam logic [3:0] REG_HOUR = 4'h2;

    // BCD wrap limits
    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;

    // Bus protocol FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_ARMED = 2'd2,
        ST_DATA  = 2'd3
    } state_e;

    // Two-digit BCD increment; a low digit of 9 or above carries into the
    // high digit, so illegal host-written values still move forward.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (lo >= 4'd9) begin
            return {hi + 4'd1, 4'd0};
        end
        return {hi, lo + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer, parameterizable width; flops reset to
//               RST_VAL (all ones by default = strobes inactive).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    // Next values for the two synchronizer stages
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    // Synchronizer flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/rtc_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rtc_bus_responder
// Description : Responder for the multiplexed RTC bus. Decodes the address and
//               data phases, serves a small register file and keeps a
//               free-running BCD hh:mm:ss clock in registers 0..2.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_responder #(
    parameter int TICK_DIV = 100_000_000,
    parameter int NREG     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ChipSelect,
    input  logic       AoD,
    input  logic       Write,
    input  logic       Read,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       bus_err
);
    import rtc_pkg::*;

    localparam int          PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam int          SEC        = int'(REG_SEC);
    localparam int          MIN        = int'(REG_MIN);
    localparam int          HOUR       = int'(REG_HOUR);

    logic [3:0]    strobe_s;
    logic          cs_s, aod_s, wr_s, rd_s;
    logic [7:0]    din1_q, din1_d, din2_q, din2_d;
    logic          wr_prev_q, wr_prev_d;
    logic          err_q, err_d;
    logic          wr_bad_q, wr_bad_d;
    logic          wr_rise, err, wr_en, wr_time, tick;
    state_e        state_q, state_d;
    logic [3:0]    addr_q, addr_d;
    logic          addr_valid_q, addr_valid_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    regs_q [NREG];
    logic [7:0]    regs_d [NREG];
    logic [7:0]    rd_val;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_oe_q, data_oe_d;
    logic          bus_err_q, bus_err_d;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_strobe_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async ({ChipSelect, AoD, Write, Read}),
        .o_sync  (strobe_s)
    );

    assign {cs_s, aod_s, wr_s, rd_s} = strobe_s;

    // Strobe decode: data alignment, write edge, protocol-error detection
    always_comb begin
        din1_d    = data_in;
        din2_d    = din1_q;
        wr_prev_d = wr_s;
        wr_rise   = !wr_prev_q && wr_s;
        err       = !cs_s && !rd_s && (!wr_s || state_q == ST_ADDR);
        err_d     = err;
        // A write strobe that overlapped an error never commits on its rise
        wr_bad_d  = err ? 1'b1 : (wr_s ? 1'b0 : wr_bad_q);
        wr_en     = (state_q == ST_DATA) && !cs_s && wr_rise && !err && !wr_bad_q;
        wr_time   = wr_en && (addr_q <= REG_HOUR);
    end

    // Read mux; addresses beyond the register file return zero
    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            if (addr_q == 4'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    // FSM next state and next registered outputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        if (!err) begin
            case (state_q)
                ST_IDLE: begin
                    if (!cs_s && !aod_s) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    if (cs_s) begin
                        state_d = addr_valid_q ? ST_ARMED : ST_IDLE;
                    end else if (wr_rise && !wr_bad_q) begin
                        addr_d       = din2_q[3:0];
                        addr_valid_d = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!cs_s) state_d = aod_s ? ST_DATA : ST_ADDR;
                end
                ST_DATA: begin
                    if (cs_s) begin
                        state_d      = ST_IDLE;
                        addr_valid_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        data_oe_d  = (state_q == ST_DATA) && !cs_s && !rd_s && !err;
        data_out_d = data_oe_d ? rd_val : 8'h00;
        bus_err_d  = err && !err_q;
    end

    // Prescaler, BCD clock and host writes; a time write drops the whole tick
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        regs_d  = regs_q;
        if (tick && !wr_time) begin
            if (regs_q[SEC] == BCD_59) begin
                regs_d[SEC] = 8'h00;
                if (regs_q[MIN] == BCD_59) begin
                    regs_d[MIN]  = 8'h00;
                    regs_d[HOUR] = (regs_q[HOUR] == BCD_23) ? 8'h00 : bcd_inc(regs_q[HOUR]);
                end else begin
                    regs_d[MIN] = bcd_inc(regs_q[MIN]);
                end
            end else begin
                regs_d[SEC] = bcd_inc(regs_q[SEC]);
            end
        end
        for (int i = 0; i < NREG; i++) begin
            if (wr_en && addr_q == 4'(i)) begin
                regs_d[i] = din2_q;
            end
        end
    end

    // Data pipeline and strobe history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din1_q    <= 8'h00;
            din2_q    <= 8'h00;
            wr_prev_q <= 1'b1;
            err_q     <= 1'b0;
            wr_bad_q  <= 1'b0;
        end else begin
            din1_q    <= din1_d;
            din2_q    <= din2_d;
            wr_prev_q <= wr_prev_d;
            err_q     <= err_d;
            wr_bad_q  <= wr_bad_d;
        end
    end

    // FSM state, latched address and registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 4'h0;
            addr_valid_q <= 1'b0;
            data_out_q   <= 8'h00;
            data_oe_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Register file and prescaler
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            presc_q <= presc_d;
            regs_q  <= regs_d;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign bus_err  = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_responder
// Description : Directed self-checking bench for rtc_bus_responder using
//               generator-shaped 32-cycle bus frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_responder;

    localparam int TICK_DIV = 4;
    localparam int NREG     = 8;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       ChipSelect = 1'b1;
    logic       AoD        = 1'b0;
    logic       Write      = 1'b1;
    logic       Read       = 1'b1;
    logic [7:0] data_in    = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic       bus_err;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt;

    rtc_bus_responder #(
        .TICK_DIV (TICK_DIV),
        .NREG     (NREG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ChipSelect (ChipSelect),
        .AoD        (AoD),
        .Write      (Write),
        .Read       (Read),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    // Edges since reset release; seconds tick on every edge where ecnt%4==0
    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leave the bench just after an edge whose count is congruent to k mod 4
    task automatic align(input int k);
        do begin
            @(posedge clk);
            #1;
        end while ((ecnt % 4) != k);
    endtask

    // One generator frame. kind: 0 = write, 1 = read, 2 = read+write together.
    // CS low 1-8 (address) and 20-27 (data); Write low 2-7; data strobe 21-26.
    task automatic run_frame(input string name, input int kind, input logic [7:0] addr,
                             input logic [7:0] wd, input logic [7:0] e24,
                             input logic [7:0] e29, input int abort_c);
        int   pulses = 0;
        logic exp_oe;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            #1;
            ChipSelect = !((c <= 8) || (c >= 20 && c <= 27));
            AoD        = (c >= 10 && c <= 30);
            Write      = !((c >= 2 && c <= 7) || (kind != 1 && c >= 21 && c <= 26));
            Read       = !(kind != 0 && c >= 21 && c <= 26);
            data_in    = (c <= 9) ? addr : wd;
            if (c == abort_c) begin
                reset = 1'b0;
                #1;
                check_eq({name, " oe_async_reset"}, {31'd0, data_oe}, 32'd0);
                check_eq({name, " dout_async_reset"}, {24'd0, data_out}, 32'd0);
                ChipSelect = 1'b1;
                AoD        = 1'b0;
                Write      = 1'b1;
                Read       = 1'b1;
                data_in    = 8'h00;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            @(negedge clk);
            exp_oe = (kind == 1) && (c >= 24) && (c <= 29);
            check_eq($sformatf("%s oe c%0d", name, c), {31'd0, data_oe}, {31'd0, exp_oe});
            if (!exp_oe)
                check_eq($sformatf("%s dout c%0d", name, c), {24'd0, data_out}, 32'd0);
            else if (c == 24)
                check_eq($sformatf("%s dout c24", name), {24'd0, data_out}, {24'd0, e24});
            else if (c == 29)
                check_eq($sformatf("%s dout c29", name), {24'd0, data_out}, {24'd0, e29});
            if (bus_err) pulses++;
        end
        check_eq({name, " bus_err pulses"}, pulses, (kind == 2) ? 32'd1 : 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset data_out", {24'd0, data_out}, 32'd0);
        check_eq("reset data_oe", {31'd0, data_oe}, 32'd0);
        check_eq("reset bus_err", {31'd0, bus_err}, 32'd0);
        reset = 1'b1;

        // Preload 23:59:59; sec write lands 2 edges before a tick -> full wrap
        run_frame("wr_min", 0, 8'h01, 8'h59, 8'h00, 8'h00, 0);
        run_frame("wr_hour", 0, 8'h02, 8'h23, 8'h00, 8'h00, 0);
        align(0);
        run_frame("wr_sec", 0, 8'h00, 8'h59, 8'h00, 8'h00, 0);
        run_frame("rd_sec_wrap", 1, 8'h00, 8'h00, 8'h05, 8'h07, 0);
        run_frame("rd_min_wrap", 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        run_frame("rd_hour_wrap", 1, 8'h02, 8'h00, 8'h00, 8'h00, 0);

        // Seconds write on a tick edge: tick dropped, count resumes from 0x30
        align(2);
        run_frame("wr_sec_tick", 0, 8'h00, 8'h30, 8'h00, 8'h00, 0);
        run_frame("rd_sec_tick", 1, 8'h00, 8'h00, 8'h36, 8'h37, 0);

        // RAM write/read, then a read+write collision that must not commit
        run_frame("wr_r5", 0, 8'h05, 8'hA7, 8'h00, 8'h00, 0);
        run_frame("rd_r5", 1, 8'h05, 8'h00, 8'hA7, 8'hA7, 0);
        run_frame("err_r5", 2, 8'h05, 8'h11, 8'h00, 8'h00, 0);
        run_frame("rd_r5_after_err", 1, 8'h05, 8'h00, 8'hA7, 8'hA7, 0);

        // Address beyond NREG: write ignored, read zero, no aliasing onto reg 4
        run_frame("wr_oor", 0, 8'h0C, 8'h55, 8'h00, 8'h00, 0);
        run_frame("rd_oor", 1, 8'h0C, 8'h00, 8'h00, 8'h00, 0);
        run_frame("rd_r4", 1, 8'h04, 8'h00, 8'h00, 8'h00, 0);

        // Asynchronous reset in the middle of a driven read
        run_frame("rd_r5_abort", 1, 8'h05, 8'h00, 8'hA7, 8'hA7, 25);
        run_frame("rd_r5_post_rst", 1, 8'h05, 8'h00, 8'h00, 8'h00, 0);
        run_frame("rd_hour_post_rst", 1, 8'h02, 8'h00, 8'h00, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
